hdlc_tx_sched: RTL and testbench

HDLC_TX_SCHED -- requirements
Module: hdlc_tx_sched

---
 rtl/hdlc_pkg.sv | 34 +++
 rtl/hdlc_rr_arb.sv | 43 ++++
 rtl/hdlc_tx_sched.sv | 202 ++++++++++++++++++++
 tb/tb_hdlc_tx_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared definitions for the HDLC transmit scheduler: the scheduler state
// encoding, the HDLC register addresses, and the Tx SC control bit positions
// together with the SC write values built from them.
// -----------------------------------------------------------------------------
package hdlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_ABORT = 3'd4,
        ST_FIN   = 3'd5
    } tx_state_t;

    // HDLC register addresses
    localparam logic [2:0] TX_SC   = 3'd0;
    localparam logic [2:0] TX_BUFF = 3'd1;

    // Tx SC bit positions
    localparam int SC_TX_ENABLE_BIT = 1;
    localparam int SC_TX_ABORT_BIT  = 2;

    // Values written to Tx SC to start or abort a transmission
    localparam logic [7:0] SC_TX_ENABLE = 8'h01 << SC_TX_ENABLE_BIT;
    localparam logic [7:0] SC_TX_ABORT  = 8'h01 << SC_TX_ABORT_BIT;

    // Tx_Done can still show the previous frame's status right after the
    // enable write, so it is ignored for this many BUSY cycles.
    localparam logic [1:0] BUSY_IGNORE_CYCLES = 2'd2;

endpackage

// File: rtl/hdlc_rr_arb.sv
// -----------------------------------------------------------------------------
// hdlc_rr_arb
// Two-requester round-robin arbiter. The grant is combinational from Req; the
// pointer register remembers which requester wins a tie, and it moves away
// from the winner whenever the owner accepts the grant (Update).
//
// Ports
//   Clk    : clock, rising edge
//   Rst    : asynchronous active-low reset (pointer favours requester 0)
//   Req    : [1:0] requests
//   Update : the current grant is consumed; advance the pointer
//   Gnt    : [1:0] one-hot grant, 0 when nothing is requested
// -----------------------------------------------------------------------------
module hdlc_rr_arb (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Req,
    input  logic       Update,
    output logic [1:0] Gnt
);

    // Requester that wins when both request at once
    logic prio_q;

    always_comb begin
        Gnt = Req;
        if (Req == 2'b11) begin
            Gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prio_q <= 1'b0;
        end else if (Update && (Gnt != 2'b00)) begin
            // NOTE: registers are updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            // The winner just served drops to lowest priority.
            prio_q <= ~Gnt[1];
        end
    end

endmodule

// File: rtl/hdlc_tx_sched.sv
// -----------------------------------------------------------------------------
// hdlc_tx_sched
// Schedules frames from two requesters onto a single HDLC transmitter.
// A granted frame is copied byte by byte into Tx_Buff, then transmission is
// started through Tx SC. The owner may abort while loading or transmitting.
// Frames with an illegal length are rejected without touching the HDLC core.
//
// Ports
//   Clk             : clock, rising edge
//   Rst             : asynchronous active-low reset
//   Req_Valid[i]    : requester i has a frame pending
//   Req_Len[i]      : frame length in bytes, stable while Req_Valid[i]
//   Req_Data[i]     : current byte of requester i
//   Req_Pop[i]      : byte of requester i consumed this cycle
//   Req_Abort[i]    : requester i cancels its frame
//   Grant           : one-hot owner of the Tx path, 0 when idle
//   Done            : one-cycle pulse, frame fully sent
//   Aborted         : one-cycle pulse, frame aborted or rejected
//   Address         : HDLC register address
//   WriteEnable     : HDLC register write strobe
//   DataIn          : HDLC register write data
//   Tx_Done         : HDLC transmitter idle
//   Tx_Full         : HDLC Tx buffer full
//   Tx_AbortedTrans : HDLC reports the transmission was aborted
// -----------------------------------------------------------------------------
module hdlc_tx_sched
    import hdlc_pkg::*;
#(
    parameter int MAX_LEN = 126
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [1:0]      Req_Valid,
    input  logic [1:0][7:0] Req_Len,
    input  logic [1:0][7:0] Req_Data,
    output logic [1:0]      Req_Pop,
    input  logic [1:0]      Req_Abort,
    output logic [1:0]      Grant,
    output logic [1:0]      Done,
    output logic [1:0]      Aborted,
    output logic [2:0]      Address,
    output logic            WriteEnable,
    output logic [7:0]      DataIn,
    input  logic            Tx_Done,
    input  logic            Tx_Full,
    input  logic            Tx_AbortedTrans
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    tx_state_t  state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] busy_cnt_q, busy_cnt_d;
    logic       abt_wr_q, abt_wr_d;       // ABORT still owes its SC write
    logic [1:0] pulse_abt_q, pulse_abt_d; // registered Aborted pulse

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_update;
    logic [7:0] arb_len;
    logic [7:0] cur_len;
    logic [7:0] cnt_inc;
    logic       len_ok;
    logic       abort_g;

    // Arbitrate only in IDLE with the transmitter free. While an Aborted pulse
    // is out, hold off so the requester can withdraw the rejected frame.
    assign arb_req = (state_q == ST_IDLE && pulse_abt_q == 2'b00 && Tx_Done)
                     ? Req_Valid : 2'b00;

    hdlc_rr_arb u_arb (
        .Clk    (Clk),
        .Rst    (Rst),
        .Req    (arb_req),
        .Update (arb_update),
        .Gnt    (arb_gnt)
    );

    assign arb_len = Req_Len[arb_gnt[1]];
    assign cur_len = Req_Len[grant_q[1]];
    assign cnt_inc = cnt_q + 8'd1;
    assign len_ok  = (arb_len != 8'd0) && (arb_len <= MAX_LEN_B);
    // Only the current owner can abort; other requesters' aborts are ignored.
    assign abort_g = |(Req_Abort & grant_q);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            cnt_q       <= 8'd0;
            busy_cnt_q  <= 2'd0;
            abt_wr_q    <= 1'b0;
            pulse_abt_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            abt_wr_q    <= abt_wr_d;
            pulse_abt_q <= pulse_abt_d;
        end
    end

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        busy_cnt_d  = busy_cnt_q;
        abt_wr_d    = abt_wr_q;
        pulse_abt_d = 2'b00;
        arb_update  = 1'b0;

        Grant       = grant_q;
        Done        = 2'b00;
        Aborted     = pulse_abt_q;
        Req_Pop     = 2'b00;
        WriteEnable = 1'b0;
        Address     = TX_SC;
        DataIn      = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    arb_update = 1'b1;
                    if (len_ok) begin
                        grant_d = arb_gnt;
                        cnt_d   = 8'd0;
                        state_d = ST_LOAD;
                    end else begin
                        // Rejected: report it, never touch the HDLC core.
                        pulse_abt_d = arb_gnt;
                    end
                end
            end

            ST_LOAD: begin
                // The byte on offer is written even when an abort arrives in
                // the same cycle, so the requester's pop count stays exact.
                if (!Tx_Full) begin
                    WriteEnable = 1'b1;
                    Address     = TX_BUFF;
                    DataIn      = Req_Data[grant_q[1]];
                    Req_Pop     = grant_q;
                    cnt_d       = cnt_inc;
                end
                if (abort_g) begin
                    abt_wr_d = 1'b1;
                    state_d  = ST_ABORT;
                end else if (!Tx_Full && cnt_inc == cur_len) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                WriteEnable = 1'b1;
                Address     = TX_SC;
                DataIn      = SC_TX_ENABLE;
                busy_cnt_d  = 2'd0;
                state_d     = ST_BUSY;
            end

            ST_BUSY: begin
                if (abort_g) begin
                    abt_wr_d = 1'b1;
                    state_d  = ST_ABORT;
                end else if (busy_cnt_q != BUSY_IGNORE_CYCLES) begin
                    busy_cnt_d = busy_cnt_q + 2'd1;
                end else if (Tx_Done) begin
                    state_d = ST_FIN;
                end
            end

            ST_ABORT: begin
                if (abt_wr_q) begin
                    WriteEnable = 1'b1;
                    Address     = TX_SC;
                    DataIn      = SC_TX_ABORT;
                    abt_wr_d    = 1'b0;
                end else if (Tx_AbortedTrans || Tx_Done) begin
                    pulse_abt_d = grant_q;
                    grant_d     = 2'b00;
                    state_d     = ST_IDLE;
                end
            end

            ST_FIN: begin
                Done    = grant_q;
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hdlc_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_hdlc_tx_sched
// Directed bench for hdlc_tx_sched. Inputs change 2 ns after each rising edge
// and outputs are sampled 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_hdlc_tx_sched;

    logic            Clk;
    logic            Rst;
    logic [1:0]      Req_Valid;
    logic [1:0][7:0] Req_Len;
    logic [1:0][7:0] Req_Data;
    logic [1:0]      Req_Pop;
    logic [1:0]      Req_Abort;
    logic [1:0]      Grant;
    logic [1:0]      Done;
    logic [1:0]      Aborted;
    logic [2:0]      Address;
    logic            WriteEnable;
    logic [7:0]      DataIn;
    logic            Tx_Done;
    logic            Tx_Full;
    logic            Tx_AbortedTrans;

    int n_tests = 0;
    int n_fail  = 0;

    hdlc_tx_sched #(.MAX_LEN(126)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Req_Valid       (Req_Valid),
        .Req_Len         (Req_Len),
        .Req_Data        (Req_Data),
        .Req_Pop         (Req_Pop),
        .Req_Abort       (Req_Abort),
        .Grant           (Grant),
        .Done            (Done),
        .Aborted         (Aborted),
        .Address         (Address),
        .WriteEnable     (WriteEnable),
        .DataIn          (DataIn),
        .Tx_Done         (Tx_Done),
        .Tx_Full         (Tx_Full),
        .Tx_AbortedTrans (Tx_AbortedTrans)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_grant"}, 32'(Grant), 32'h0);
        chk({tag, "_we"},    32'(WriteEnable), 32'h0);
        chk({tag, "_pop"},   32'(Req_Pop), 32'h0);
        chk({tag, "_addr"},  32'(Address), 32'h0);
        chk({tag, "_data"},  32'(DataIn), 32'h0);
        chk({tag, "_done"},  32'(Done), 32'h0);
        chk({tag, "_abt"},   32'(Aborted), 32'h0);
    endtask

    initial begin
        logic [1:0] exp_g;
        int t;

        Rst             = 1'b0;
        Req_Valid       = 2'b00;
        Req_Len         = '0;
        Req_Data        = '0;
        Req_Abort       = 2'b00;
        Tx_Done         = 1'b1;
        Tx_Full         = 1'b0;
        Tx_AbortedTrans = 1'b0;

        // ---- reset state ----
        #3;
        chk_idle_outs("reset");
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        tick();

        // ---- single frame: AA BB CC from requester 0 ----
        Req_Valid = 2'b01; Req_Len[0] = 8'd3; Req_Data[0] = 8'hAA;
        #1 chk("t1_idle_grant", 32'(Grant), 32'h0);
        tick(); #1;
        chk("t1_b0_grant", 32'(Grant), 32'h1);
        chk("t1_b0_we",    32'(WriteEnable), 32'h1);
        chk("t1_b0_addr",  32'(Address), 32'h1);
        chk("t1_b0_data",  32'(DataIn), 32'hAA);
        chk("t1_b0_pop",   32'(Req_Pop), 32'h1);
        tick(); Req_Data[0] = 8'hBB; #1;
        chk("t1_b1_data",  32'(DataIn), 32'hBB);
        chk("t1_b1_pop",   32'(Req_Pop), 32'h1);
        tick(); Req_Data[0] = 8'hCC; #1;
        chk("t1_b2_data",  32'(DataIn), 32'hCC);
        chk("t1_b2_addr",  32'(Address), 32'h1);
        tick(); #1;
        chk("t1_start_we",   32'(WriteEnable), 32'h1);
        chk("t1_start_addr", 32'(Address), 32'h0);
        chk("t1_start_data", 32'(DataIn), 32'h02);
        chk("t1_start_pop",  32'(Req_Pop), 32'h0);
        // Tx_Done is held 1 throughout: the first two BUSY cycles must ignore it
        tick(); #1;
        chk("t1_busy0_we",   32'(WriteEnable), 32'h0);
        chk("t1_busy0_done", 32'(Done), 32'h0);
        tick(); #1 chk("t1_busy1_done", 32'(Done), 32'h0);
        tick(); #1 chk("t1_busy2_done", 32'(Done), 32'h0);
        tick(); #1 chk("t1_fin_done", 32'(Done), 32'h1);
        Req_Valid = 2'b00;
        tick(); #1;
        chk("t1_after_done",  32'(Done), 32'h0);
        chk("t1_after_grant", 32'(Grant), 32'h0);

        // ---- backpressure: 4 stall cycles in the middle of LOAD ----
        Req_Valid = 2'b01; Req_Len[0] = 8'd4; Req_Data[0] = 8'h11;
        tick(); #1 chk("t2_b0_data", 32'(DataIn), 32'h11);
        tick(); Req_Data[0] = 8'h22; #1 chk("t2_b1_data", 32'(DataIn), 32'h22);
        for (int i = 0; i < 4; i++) begin
            tick(); Req_Data[0] = 8'h33; Tx_Full = 1'b1; #1;
            chk("t2_stall_we",  32'(WriteEnable), 32'h0);
            chk("t2_stall_pop", 32'(Req_Pop), 32'h0);
        end
        tick(); Tx_Full = 1'b0; #1;
        chk("t2_b2_we",   32'(WriteEnable), 32'h1);
        chk("t2_b2_data", 32'(DataIn), 32'h33);
        chk("t2_b2_pop",  32'(Req_Pop), 32'h1);
        tick(); Req_Data[0] = 8'h44; #1;
        chk("t2_b3_data", 32'(DataIn), 32'h44);
        chk("t2_b3_addr", 32'(Address), 32'h1);
        tick(); #1 chk("t2_start_data", 32'(DataIn), 32'h02);
        t = 0;
        do begin tick(); #1; t++; end while (Done == 2'b00 && t < 10);
        chk("t2_done", 32'(Done), 32'h1);
        Req_Valid = 2'b00;
        tick();

        // ---- abort from requester 1 during BUSY ----
        Req_Valid = 2'b10; Req_Len[1] = 8'd2; Req_Data[1] = 8'hD1;
        tick(); #1;
        chk("t3_grant",   32'(Grant), 32'h2);
        chk("t3_b0_data", 32'(DataIn), 32'hD1);
        chk("t3_b0_pop",  32'(Req_Pop), 32'h2);
        tick(); Req_Data[1] = 8'hD2; #1 chk("t3_b1_data", 32'(DataIn), 32'hD2);
        // abort during START is ignored
        tick(); Req_Abort = 2'b10; Tx_Done = 1'b0; #1;
        chk("t3_start_data", 32'(DataIn), 32'h02);
        // abort from the non-owner is ignored
        tick(); Req_Abort = 2'b01; #1 chk("t3_busy0_we", 32'(WriteEnable), 32'h0);
        tick(); Req_Abort = 2'b10; #1;
        chk("t3_busy1_we",    32'(WriteEnable), 32'h0);
        chk("t3_busy1_grant", 32'(Grant), 32'h2);
        tick(); Req_Abort = 2'b00; #1;
        chk("t3_abort_we",   32'(WriteEnable), 32'h1);
        chk("t3_abort_addr", 32'(Address), 32'h0);
        chk("t3_abort_data", 32'(DataIn), 32'h04);
        tick(); #1;
        chk("t3_wait1_we",  32'(WriteEnable), 32'h0);
        chk("t3_wait1_abt", 32'(Aborted), 32'h0);
        tick(); Tx_AbortedTrans = 1'b1; #1 chk("t3_wait2_abt", 32'(Aborted), 32'h0);
        tick(); Tx_AbortedTrans = 1'b0; Req_Valid = 2'b00; Tx_Done = 1'b1; #1;
        chk("t3_abt_pulse", 32'(Aborted), 32'h2);
        chk("t3_abt_grant", 32'(Grant), 32'h0);
        tick(); #1 chk("t3_abt_clear", 32'(Aborted), 32'h0);

        // ---- fairness: both requesters valid, grants alternate 0,1,0,1 ----
        Req_Valid = 2'b11; Req_Len[0] = 8'd1; Req_Len[1] = 8'd1;
        Req_Data[0] = 8'h5A; Req_Data[1] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            t = 0;
            do begin tick(); #1; t++; end while (Grant == 2'b00 && t < 20);
            chk("t4_grant", 32'(Grant), 32'(exp_g));
            chk("t4_data",  32'(DataIn), (exp_g == 2'b01) ? 32'h5A : 32'hA5);
            t = 0;
            do begin tick(); #1; t++; end while (Done == 2'b00 && t < 20);
            chk("t4_done", 32'(Done), 32'(exp_g));
        end
        Req_Valid = 2'b00;
        tick(); #1 chk("t4_idle_grant", 32'(Grant), 32'h0);

        // ---- rejected lengths: 0 and 127 ----
        Req_Valid = 2'b01; Req_Len[0] = 8'd0;
        tick(); #1;
        chk("t5_len0_abt",   32'(Aborted), 32'h1);
        chk("t5_len0_grant", 32'(Grant), 32'h0);
        chk("t5_len0_we",    32'(WriteEnable), 32'h0);
        Req_Valid = 2'b00;
        tick(); #1 chk("t5_len0_clear", 32'(Aborted), 32'h0);
        Req_Valid = 2'b10; Req_Len[1] = 8'd127;
        tick(); #1;
        chk("t5_len127_abt",   32'(Aborted), 32'h2);
        chk("t5_len127_grant", 32'(Grant), 32'h0);
        chk("t5_len127_we",    32'(WriteEnable), 32'h0);
        Req_Valid = 2'b00;
        tick(); #1;
        chk("t5_len127_clear", 32'(Aborted), 32'h0);
        chk("t5_len127_we2",   32'(WriteEnable), 32'h0);

        // ---- abort together with the last LOAD byte ----
        Req_Valid = 2'b01; Req_Len[0] = 8'd2; Req_Data[0] = 8'hE1;
        tick(); #1 chk("t6_b0_data", 32'(DataIn), 32'hE1);
        tick(); Req_Data[0] = 8'hE2; Req_Abort = 2'b01; #1;
        chk("t6_b1_we",   32'(WriteEnable), 32'h1);
        chk("t6_b1_data", 32'(DataIn), 32'hE2);
        chk("t6_b1_pop",  32'(Req_Pop), 32'h1);
        tick(); Req_Abort = 2'b00; #1;
        chk("t6_abort_addr", 32'(Address), 32'h0);
        chk("t6_abort_data", 32'(DataIn), 32'h04);
        tick(); #1 chk("t6_wait_abt", 32'(Aborted), 32'h0);
        tick(); Req_Valid = 2'b00; #1;
        chk("t6_abt_pulse", 32'(Aborted), 32'h1);
        chk("t6_abt_grant", 32'(Grant), 32'h0);
        tick();

        // ---- MAX_LEN accepted, then reset in the middle of LOAD ----
        Req_Valid = 2'b01; Req_Len[0] = 8'd126; Req_Data[0] = 8'h77;
        tick(); #1;
        chk("t7_grant", 32'(Grant), 32'h1);
        chk("t7_we",    32'(WriteEnable), 32'h1);
        tick(); #1 chk("t7_we2", 32'(WriteEnable), 32'h1);
        Rst = 1'b0;
        #1 chk_idle_outs("t7_rst");
        Req_Valid = 2'b11; Req_Len[1] = 8'd1;
        @(negedge Clk);
        Rst = 1'b1;
        #1 chk("t7_post_rst_grant", 32'(Grant), 32'h0);
        // The pointer reset favours requester 0 again
        tick(); #1;
        chk("t7_rr_reset_grant", 32'(Grant), 32'h1);
        chk("t7_rr_reset_data",  32'(DataIn), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
